bank_stream_reader: RTL and testbench
=====================================

Name: bank_stream_reader

Overview:
- Read-side initiator for the GEMM banked operand memory. It drives port B of all NUM_RAMS banks in lockstep.
- Accepts a command (base address, row count) and issues one read per cycle to every bank at the same address.
- Absorbs the 1-cycle BRAM read latency and presents each NUM_RAMS-wide row on a valid/ready stream toward the systolic-array feeder.
- Full throughput (1 row/cycle) when the consumer is always ready; lossless under arbitrary backpressure.

Parameters:
NUM_RAMS, 2, number of banks read in parallel (row width in words)
A_WID, 10, bank address width
D_WID, 32, bank data word width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE
cmd_base  input  A_WID  first row address
cmd_len  input  A_WID+1  number of rows (0..2^A_WID)
enb  output  NUM_RAMS  per-bank port-B enable (all bits identical)
web  output  NUM_RAMS  per-bank port-B write enable, constant 0
addrb  output  A_WID x NUM_RAMS (unpacked)  per-bank port-B address (all identical)
dinb  output  D_WID x NUM_RAMS (unpacked)  constant 0
doutb  input  D_WID x NUM_RAMS (unpacked)  bank read data, valid 1 cycle after enb
out_valid  output  1  row available
out_ready  input  1  consumer accepts row
out_data  output  D_WID x NUM_RAMS (unpacked)  row; element i from bank i
out_last  output  1  qualifies final row of command
done  output  1  1-cycle pulse after last row handshakes

Behaviour:
- Reset (async, any state, mid-command included): FSM=IDLE, enb=0, addrb=0, out_valid=0, out_last=0, done=0, buffer emptied, in-flight read discarded. cmd_ready=1 from the first cycle after reset deasserts.
- FSM states: IDLE, READ, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid & cmd_ready, latch base/len; addr_ctr=base, issue_rem=len, out_rem=len.
  - len!=0 -> READ.
  - len==0 -> done=1 next cycle, stay IDLE, no bank access.
- Output buffer: 2-entry FIFO of rows (plus last flag). occ=0..2; infl=0/1 (read issued last cycle).
- Issue rule, READ: issue this cycle iff issue_rem>0 and (occ + infl - pop) < 2, where pop = out_valid & out_ready.
  - On issue: enb=all ones, addrb[i]=addr_ctr, addr_ctr+=1 modulo 2^A_WID (wraps 2^A_WID-1 -> 0), issue_rem-=1.
  - enb and addrb are combinational from state/counters. enb=0 whenever not issuing; addrb holds last value.
- Capture: the cycle after an issue (infl=1), doutb is written into the buffer tail. Rows are never dropped; the issue rule guarantees space.
- Simultaneous push and pop: occ unchanged, order preserved.
- out_data/out_valid come from the buffer head (registered path, no combinational doutb->out_data when occ>0). Holding rules:
  - out_valid, once asserted, stays high until handshake.
  - out_data stays stable while out_valid & !out_ready.
- out_last=1 on the head row iff out_rem==1. On each pop, out_rem-=1.
- READ -> DRAIN when the final read issues (issue_rem 1->0).
- DRAIN -> IDLE on the handshake of the final row; done=1 the following cycle, coincident with return of cmd_ready.
- Throughput: with out_ready held high, first out_valid is 2 cycles after the cmd handshake (issue at cycle +1, capture at +2), then 1 row/cycle. A command of N rows completes with done at cycle N+3.
- web=0 and dinb=0 always; this block never writes.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Test Plan:
- Reset values: assert rst mid-cycle with no clock edge -> enb=0, out_valid=0, done=0, cmd_ready=0 immediately. After release, cmd_ready=1.
- Streaming: NUM_RAMS=2, bank i preloaded with word = (i<<16)|addr; cmd base=5, len=4, out_ready=1 -> rows {0x00005,0x10005}..{0x00008,0x10008} on consecutive cycles; out_last on 4th row; done exactly 1 cycle after the 4th handshake.
- Backpressure: same command with out_ready toggling 1,0,0,1,0,1... -> no row lost or duplicated, out_data stable while stalled, enb never leaves occ+infl above 2.
- Address wrap: cmd base=1022, len=4, A_WID=10 -> addrb sequence 1022,1023,0,1; data matches.
- Zero-length command: cmd len=0 -> enb never asserted, out_valid stays 0, done pulses the cycle after accept.
- Reset mid-command: rst asserted after 2 of 8 rows delivered -> outputs cleared; a fresh command base=0, len=3 then returns exactly 3 correct rows with no stale data.

Source files
------------

// File: rtl/bank_stream_reader.sv
// rtl/bank_stream_reader.sv - banked operand memory read initiator with valid/ready row output
module bank_stream_reader #(
    parameter int NUM_RAMS = 2,
    parameter int A_WID    = 10,
    parameter int D_WID    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [A_WID-1:0]    cmd_base,
    input  logic [A_WID:0]      cmd_len,
    output logic [NUM_RAMS-1:0] enb,
    output logic [NUM_RAMS-1:0] web,
    output logic [A_WID-1:0]    addrb [NUM_RAMS],
    output logic [D_WID-1:0]    dinb [NUM_RAMS],
    input  logic [D_WID-1:0]    doutb [NUM_RAMS],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [D_WID-1:0]    out_data [NUM_RAMS],
    output logic                out_last,
    output logic                done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [A_WID:0] ONE_ROW = {{A_WID{1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [A_WID-1:0] addr_ctr;
    logic [A_WID-1:0] last_addr;
    logic [A_WID:0]   issue_rem;
    logic [A_WID:0]   out_rem;
    logic             infl;
    logic [1:0]       occ;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [D_WID-1:0] buf_data [2][NUM_RAMS];

    logic       accept;
    logic       pop;
    logic       issue;
    logic [2:0] pending;

    // A read issued now lands in the buffer one cycle later; count it against space now.
    always_comb begin
        accept  = cmd_valid & cmd_ready;
        pop     = out_valid & out_ready;
        pending = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
        issue   = (state == S_READ) && (issue_rem != '0) && (pending < 3'd2);
    end

    assign cmd_ready = (state == S_IDLE) && !rst;
    assign out_valid = (occ != 2'd0);
    assign out_last  = out_valid && (out_rem == ONE_ROW);

    for (genvar i = 0; i < NUM_RAMS; i++) begin : g_bank
        assign enb[i]      = issue;
        assign web[i]      = 1'b0;
        assign addrb[i]    = issue ? addr_ctr : last_addr;
        assign dinb[i]     = '0;
        assign out_data[i] = buf_data[rd_ptr][i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr_ctr  <= '0;
            last_addr <= '0;
            issue_rem <= '0;
            out_rem   <= '0;
            infl      <= 1'b0;
            occ       <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            infl <= issue;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_ctr  <= cmd_base;
                        issue_rem <= cmd_len;
                        out_rem   <= cmd_len;
                        if (cmd_len != '0) state <= S_READ;
                        else done <= 1'b1;
                    end
                end
                S_READ: begin
                    if (issue && issue_rem == ONE_ROW) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && out_rem == ONE_ROW) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (issue) begin
                addr_ctr  <= addr_ctr + 1'b1;
                last_addr <= addr_ctr;
                issue_rem <= issue_rem - 1'b1;
            end
            if (infl) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr  <= ~rd_ptr;
                out_rem <= out_rem - 1'b1;
            end
            occ <= occ + {1'b0, infl} - {1'b0, pop};
        end
    end

    // Row storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (infl) begin
            for (int i = 0; i < NUM_RAMS; i++) buf_data[wr_ptr][i] <= doutb[i];
        end
    end

endmodule

// File: tb/tb_bank_stream_reader.sv
// tb/tb_bank_stream_reader.sv - scoreboard bench for bank_stream_reader
module tb_bank_stream_reader;
    localparam int NR    = 2;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_base;
    logic [AW:0]    cmd_len;
    logic [NR-1:0]  enb;
    logic [NR-1:0]  web;
    logic [AW-1:0]  addrb [NR];
    logic [DW-1:0]  dinb [NR];
    logic [DW-1:0]  doutb [NR];
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data [NR];
    logic           out_last;
    logic           done;

    bank_stream_reader #(.NUM_RAMS(NR), .A_WID(AW), .D_WID(DW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .enb(enb), .web(web),
        .addrb(addrb), .dinb(dinb), .doutb(doutb), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [NR][DEPTH];
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) if (enb[i]) doutb[i] <= mem[i][addrb[i]];
    end

    typedef struct packed {
        logic                  last;
        logic [NR-1:0][DW-1:0] d;
    } row_t;

    row_t exp_q[$];
    int   exp_addr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   rows_seen = 0;
    int   issued = 0;
    int   popped = 0;
    logic prev_stall = 1'b0;
    logic [NR-1:0][DW-1:0] prev_data;
    logic done_exp = 1'b0;
    int   ready_mode = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model and monitor: a command expands into its address list and rows.
    always @(negedge clk) begin
        logic [NR-1:0][DW-1:0] cur;
        logic dn;
        row_t e;
        int a;
        if (rst) begin
            exp_q.delete();
            exp_addr_q.delete();
            issued = 0;
            popped = 0;
            prev_stall = 1'b0;
            done_exp = 1'b0;
        end else begin
            dn = 1'b0;
            for (int i = 0; i < NR; i++) cur[i] = out_data[i];
            chk("done", done, done_exp);
            chk("web", web, '0);
            for (int i = 0; i < NR; i++) chk("dinb", dinb[i], '0);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", cur, prev_data);
            end
            if (enb != '0) begin
                chk("enb_uniform", enb, {NR{1'b1}});
                if (exp_addr_q.size() == 0) chk("unexpected_read", 1, 0);
                else begin
                    a = exp_addr_q.pop_front();
                    for (int i = 0; i < NR; i++) chk("addrb", addrb[i], a);
                end
            end
            chk("outstanding", (issued + int'(enb != '0) - popped - int'(out_valid && out_ready)) <= 2, 1);
            if (enb != '0) issued++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_row", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("row_data", cur, e.d);
                    chk("row_last", out_last, e.last);
                    if (e.last) dn = 1'b1;
                end
                popped++;
                rows_seen++;
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_len == 0) dn = 1'b1;
                for (int k = 0; k < int'(cmd_len); k++) begin
                    a = (int'(cmd_base) + k) % DEPTH;
                    exp_addr_q.push_back(a);
                    for (int i = 0; i < NR; i++) e.d[i] = mem[i][a];
                    e.last = (k == int'(cmd_len) - 1);
                    exp_q.push_back(e);
                end
            end
            done_exp = dn;
            prev_stall = out_valid && !out_ready;
            prev_data = cur;
        end
    end

    initial begin
        int pidx;
        logic pat [6];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pidx = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin out_ready = pat[pidx]; pidx = (pidx + 1) % 6; end
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic issue_cmd(input int base, input int len);
        int c;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        if (c == 200) chk("cmd_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_addr_q.size() == 0 && cmd_ready && !out_valid) break;
        end
        if (c == budget) chk("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_enb", enb, '0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        int start;
        int c;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_base = '0;
        cmd_len = '0;
        for (int i = 0; i < NR; i++) begin
            doutb[i] = '0;
            for (int a = 0; a < DEPTH; a++) mem[i][a] = (DW'(i) << 16) | DW'(a);
        end
        #1;
        chk("por_enb", enb, '0);
        chk("por_out_valid", out_valid, 0);
        chk("por_cmd_ready", cmd_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("por_cmd_ready_after", cmd_ready, 1);

        // Streaming with latency and back-to-back rows
        ready_mode = 0;
        issue_cmd(5, 4);
        @(negedge clk); chk("lat_c1", out_valid, 0);
        @(negedge clk); chk("lat_c2", out_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_valid", out_valid, 1);
        end
        wait_idle(100);

        ready_mode = 1;
        issue_cmd(5, 4);
        wait_idle(200);

        ready_mode = 0;
        issue_cmd(1022, 4);
        wait_idle(100);

        issue_cmd(7, 0);
        wait_idle(20);

        // Reset in the middle of an 8-row command, then a clean 3-row command
        start = rows_seen;
        issue_cmd(100, 8);
        for (c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rows_seen >= start + 2) break;
        end
        if (c == 100) chk("mid_rows_timeout", 0, 1);
        mid_reset();
        start = rows_seen;
        issue_cmd(0, 3);
        wait_idle(100);
        chk("fresh_row_count", rows_seen - start, 3);

        // Randomized contents, commands and backpressure
        for (int i = 0; i < NR; i++)
            for (int a = 0; a < DEPTH; a++) mem[i][a] = $urandom;
        for (int t = 0; t < 30; t++) begin
            ready_mode = $urandom_range(0, 2);
            issue_cmd($urandom_range(0, DEPTH - 1),
                      ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12));
            wait_idle(400);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
